// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared types and helpers for the MIPS hazard/forwarding controller.
package mips_hazard_pkg;

    // Load-use stall FSM states.
    typedef enum logic [0:0] {
        RUN     = 1'b0,
        LD_WAIT = 1'b1
    } hzState_e;

    // Forward select value meaning "take operand from the register file".
    localparam int unsigned FWD_NONE = 0;

    // Width of a forward select that encodes 0..stages.
    function automatic int unsigned selWidth(input int unsigned stages);
        return (stages < 1) ? 1 : $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/hazard_forward_ctrl_if.sv
// Pipeline-side bundle of the hazard/forwarding controller.
interface hazard_forward_ctrl_if #(
    parameter int unsigned AW         = 5,
    parameter int unsigned FWD_STAGES = 2
);
    localparam int unsigned SEL_W = mips_hazard_pkg::selWidth(FWD_STAGES);

    logic                      in_flush;
    logic [AW-1:0]             in_ID_Rs_address;
    logic [AW-1:0]             in_ID_Rt_address;
    logic                      in_ID_uses_Rt;
    logic                      in_ID_md_op;
    logic [AW-1:0]             in_ID_EX_Rs_address;
    logic [AW-1:0]             in_ID_EX_Rt_address;
    logic                      in_ID_EX_memRead;
    logic [AW-1:0]             in_ID_EX_Rd_address;
    logic                      in_ID_EX_md_start;
    logic [FWD_STAGES-1:0]     in_stage_RegWrite;
    logic [FWD_STAGES*AW-1:0]  in_stage_Rd_address;
    logic                      in_EX_MEM_memWrite;
    logic [AW-1:0]             in_EX_MEM_Rt_address;
    logic [SEL_W-1:0]          o_forwardA;
    logic [SEL_W-1:0]          o_forwardB;
    logic                      o_forward_store;
    logic                      o_stall;
    logic                      o_bubble_ID_EX;
    logic                      o_md_busy;

    modport master (
        output in_flush, in_ID_Rs_address, in_ID_Rt_address, in_ID_uses_Rt, in_ID_md_op,
               in_ID_EX_Rs_address, in_ID_EX_Rt_address, in_ID_EX_memRead,
               in_ID_EX_Rd_address, in_ID_EX_md_start, in_stage_RegWrite,
               in_stage_Rd_address, in_EX_MEM_memWrite, in_EX_MEM_Rt_address,
        input  o_forwardA, o_forwardB, o_forward_store, o_stall, o_bubble_ID_EX, o_md_busy
    );

    modport slave (
        input  in_flush, in_ID_Rs_address, in_ID_Rt_address, in_ID_uses_Rt, in_ID_md_op,
               in_ID_EX_Rs_address, in_ID_EX_Rt_address, in_ID_EX_memRead,
               in_ID_EX_Rd_address, in_ID_EX_md_start, in_stage_RegWrite,
               in_stage_Rd_address, in_EX_MEM_memWrite, in_EX_MEM_Rt_address,
        output o_forwardA, o_forwardB, o_forward_store, o_stall, o_bubble_ID_EX, o_md_busy
    );

endinterface

// File: rtl/hazard_forward_ctrl_fwd_select.sv
// N-way priority matcher: returns k+1 for the youngest (lowest k) stage
// writing a nonzero register equal to src, else FWD_NONE.
module fwd_select
    import mips_hazard_pkg::*;
#(
    parameter int unsigned AW    = 5,
    parameter int unsigned N     = 2,
    parameter int unsigned SEL_W = 2
) (
    input  logic [AW-1:0]   src,
    input  logic [N-1:0]    regWrite,
    input  logic [N*AW-1:0] rdAddr,
    output logic [SEL_W-1:0] sel
);

    // Scan oldest to youngest so the youngest match is the last one written.
    always_comb begin
        sel = SEL_W'(FWD_NONE);
        for (int k = int'(N) - 1; k >= 0; k--) begin
            if (regWrite[k] && (rdAddr[k*AW +: AW] != '0) && (rdAddr[k*AW +: AW] == src)) begin
                sel = SEL_W'(k + 1);
            end
        end
    end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard and forwarding controller: EX operand/store-data forwarding,
// load-use stalls and mult/div dependency stalls.
module hazard_forward_ctrl
    import mips_hazard_pkg::*;
#(
    parameter int unsigned AW         = 5,
    parameter int unsigned FWD_STAGES = 2,
    parameter int unsigned LOAD_LAT   = 1,
    parameter int unsigned MD_LAT     = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    hazard_forward_ctrl_if.slave  bus
);

    localparam int unsigned SEL_W = selWidth(FWD_STAGES);
    localparam int unsigned LD_W  = $clog2(LOAD_LAT + 1);
    localparam int unsigned MD_W  = $clog2(MD_LAT + 1);

    hzState_e          state;
    hzState_e          stateNext;
    logic [LD_W-1:0]   ldCnt;
    logic [LD_W-1:0]   ldCntNext;
    logic [MD_W-1:0]   mdCnt;
    logic [AW-1:0]     mdRd;

    logic [SEL_W-1:0]  selA;
    logic [SEL_W-1:0]  selB;
    logic              fwdStore;
    logic              loadUse;
    logic              mdBusy;
    logic              mdHaz;
    logic              stallC;

    fwd_select #(.AW(AW), .N(FWD_STAGES), .SEL_W(SEL_W)) u_fwd_a (
        .src      (bus.in_ID_EX_Rs_address),
        .regWrite (bus.in_stage_RegWrite),
        .rdAddr   (bus.in_stage_Rd_address),
        .sel      (selA)
    );

    fwd_select #(.AW(AW), .N(FWD_STAGES), .SEL_W(SEL_W)) u_fwd_b (
        .src      (bus.in_ID_EX_Rt_address),
        .regWrite (bus.in_stage_RegWrite),
        .rdAddr   (bus.in_stage_Rd_address),
        .sel      (selB)
    );

    // Store data in MEM can only be supplied by the MEM/WB stage (index 1).
    generate
        if (FWD_STAGES >= 2) begin : g_store
            logic storeSel;
            fwd_select #(.AW(AW), .N(1), .SEL_W(1)) u_fwd_store (
                .src      (bus.in_EX_MEM_Rt_address),
                .regWrite (bus.in_stage_RegWrite[1]),
                .rdAddr   (bus.in_stage_Rd_address[AW +: AW]),
                .sel      (storeSel)
            );
            assign fwdStore = bus.in_EX_MEM_memWrite & storeSel;
        end else begin : g_no_store
            assign fwdStore = 1'b0;
        end
    endgenerate

    assign loadUse = bus.in_ID_EX_memRead && (bus.in_ID_EX_Rd_address != '0) &&
                     ((bus.in_ID_EX_Rd_address == bus.in_ID_Rs_address) ||
                      (bus.in_ID_uses_Rt && (bus.in_ID_EX_Rd_address == bus.in_ID_Rt_address)));

    assign mdBusy = (mdCnt != '0);
    assign mdHaz  = mdBusy && (bus.in_ID_md_op ||
                    ((mdRd != '0) && ((mdRd == bus.in_ID_Rs_address) ||
                                      (bus.in_ID_uses_Rt && (mdRd == bus.in_ID_Rt_address)))));

    assign stallC = loadUse || mdHaz || (state == LD_WAIT);

    // Reset forces every output low immediately, including the combinational paths.
    assign bus.o_forwardA      = reset ? selA : SEL_W'(FWD_NONE);
    assign bus.o_forwardB      = reset ? selB : SEL_W'(FWD_NONE);
    assign bus.o_forward_store = reset & fwdStore;
    assign bus.o_stall         = reset & stallC;
    assign bus.o_bubble_ID_EX  = reset & stallC;
    assign bus.o_md_busy       = reset & mdBusy;

    // Load-use FSM state and remaining-cycle counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            ldCnt <= '0;
        end else begin
            state <= stateNext;
            ldCnt <= ldCntNext;
        end
    end

    // Load-use next state: first stall cycle is in RUN, the rest in LD_WAIT.
    always_comb begin
        stateNext = state;
        ldCntNext = ldCnt;
        unique case (state)
            RUN: begin
                if (loadUse && (LOAD_LAT > 1)) begin
                    stateNext = LD_WAIT;
                    ldCntNext = LD_W'(LOAD_LAT - 1);
                end
            end
            LD_WAIT: begin
                if (bus.in_flush || (ldCnt == LD_W'(1))) begin
                    stateNext = RUN;
                    ldCntNext = '0;
                end else begin
                    ldCntNext = ldCnt - LD_W'(1);
                end
            end
            default: begin
                stateNext = RUN;
                ldCntNext = '0;
            end
        endcase
    end

    // Mult/div in-flight tracker; independent of flush and of the load FSM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mdCnt <= '0;
            mdRd  <= '0;
        end else if (bus.in_ID_EX_md_start) begin
            mdCnt <= MD_W'(MD_LAT);
            mdRd  <= bus.in_ID_EX_Rd_address;
        end else if (mdCnt != '0) begin
            mdCnt <= mdCnt - MD_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Self-checking bench for hazard_forward_ctrl (FWD_STAGES=3, LOAD_LAT=3, MD_LAT=4).
module tb_hazard_forward_ctrl;

    localparam int unsigned AW = 5;
    localparam int unsigned FS = 3;
    localparam int unsigned LL = 3;
    localparam int unsigned ML = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;

    hazard_forward_ctrl_if #(.AW(AW), .FWD_STAGES(FS)) bus ();

    hazard_forward_ctrl #(.AW(AW), .FWD_STAGES(FS), .LOAD_LAT(LL), .MD_LAT(ML)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Stall windows are tracked as cycle intervals rather than counters.
    int cyc = 0;
    int ldStart = -100;
    int ldEnd = -100;
    int mdStart = -100;
    logic [AW-1:0] mdRdM = '0;

    function automatic int expSel(input logic [AW-1:0] src);
        for (int k = 0; k < int'(FS); k++) begin
            if (bus.in_stage_RegWrite[k] && bus.in_stage_Rd_address[k*AW +: AW] != 0 &&
                bus.in_stage_Rd_address[k*AW +: AW] == src)
                return k + 1;
        end
        return 0;
    endfunction

    function automatic logic reads(input logic [AW-1:0] r);
        return (r == bus.in_ID_Rs_address) || (bus.in_ID_uses_Rt && r == bus.in_ID_Rt_address);
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            check("rst_fwdA",  int'(bus.o_forwardA), 0);
            check("rst_fwdB",  int'(bus.o_forwardB), 0);
            check("rst_store", int'(bus.o_forward_store), 0);
            check("rst_stall", int'(bus.o_stall), 0);
            check("rst_bubble", int'(bus.o_bubble_ID_EX), 0);
            check("rst_mdbusy", int'(bus.o_md_busy), 0);
            ldStart = -100;
            ldEnd = -100;
            mdStart = -100;
            mdRdM = '0;
        end else begin
            logic luE, ldWaitE, mdBusyE, mdHazE, stallE, storeE;
            luE     = bus.in_ID_EX_memRead && bus.in_ID_EX_Rd_address != 0 && reads(bus.in_ID_EX_Rd_address);
            ldWaitE = (cyc > ldStart) && (cyc < ldEnd);
            mdBusyE = (cyc > mdStart) && (cyc <= mdStart + int'(ML));
            mdHazE  = mdBusyE && (bus.in_ID_md_op || (mdRdM != 0 && reads(mdRdM)));
            stallE  = luE || ldWaitE || mdHazE;
            storeE  = bus.in_EX_MEM_memWrite && bus.in_stage_RegWrite[1] &&
                      bus.in_stage_Rd_address[AW +: AW] != 0 &&
                      bus.in_stage_Rd_address[AW +: AW] == bus.in_EX_MEM_Rt_address;
            check("model_fwdA",  int'(bus.o_forwardA), expSel(bus.in_ID_EX_Rs_address));
            check("model_fwdB",  int'(bus.o_forwardB), expSel(bus.in_ID_EX_Rt_address));
            check("model_store", int'(bus.o_forward_store), int'(storeE));
            check("model_stall", int'(bus.o_stall), int'(stallE));
            check("model_bubble", int'(bus.o_bubble_ID_EX), int'(stallE));
            check("model_mdbusy", int'(bus.o_md_busy), int'(mdBusyE));
            if (!ldWaitE && luE) begin
                ldStart = cyc;
                ldEnd = cyc + int'(LL);
            end else if (ldWaitE && bus.in_flush) begin
                ldEnd = cyc + 1;
            end
            if (bus.in_ID_EX_md_start) begin
                mdStart = cyc;
                mdRdM = bus.in_ID_EX_Rd_address;
            end
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        bus.in_flush = 1'b0;
        bus.in_ID_Rs_address = '0;
        bus.in_ID_Rt_address = '0;
        bus.in_ID_uses_Rt = 1'b0;
        bus.in_ID_md_op = 1'b0;
        bus.in_ID_EX_Rs_address = '0;
        bus.in_ID_EX_Rt_address = '0;
        bus.in_ID_EX_memRead = 1'b0;
        bus.in_ID_EX_Rd_address = '0;
        bus.in_ID_EX_md_start = 1'b0;
        bus.in_stage_RegWrite = '0;
        bus.in_stage_Rd_address = '0;
        bus.in_EX_MEM_memWrite = 1'b0;
        bus.in_EX_MEM_Rt_address = '0;
    endtask

    task automatic setStage(input int k, input logic rw, input logic [AW-1:0] rd);
        bus.in_stage_RegWrite[k] = rw;
        bus.in_stage_Rd_address[k*AW +: AW] = rd;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        // Forwarding candidates present during reset must still read as 0.
        bus.in_ID_EX_Rs_address = 5'd8;
        setStage(0, 1'b1, 5'd8);
        #2;
        check("lit_rst_fwdA", int'(bus.o_forwardA), 0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;

        // Youngest matching stage wins; then only stage 2 matches.
        nextCycle(); idle();
        bus.in_ID_EX_Rs_address = 5'd8;
        bus.in_ID_EX_Rt_address = 5'd5;
        setStage(0, 1'b1, 5'd8); setStage(1, 1'b1, 5'd5); setStage(2, 1'b1, 5'd8);
        #1;
        check("lit_fwdA_lowest", int'(bus.o_forwardA), 1);
        check("lit_fwdB_stage1", int'(bus.o_forwardB), 2);
        nextCycle();
        setStage(0, 1'b0, 5'd8); setStage(1, 1'b0, 5'd5);
        #1;
        check("lit_fwdA_stage2", int'(bus.o_forwardA), 3);
        check("lit_fwdB_none", int'(bus.o_forwardB), 0);

        // $zero is never forwarded.
        nextCycle(); idle();
        setStage(0, 1'b1, 5'd0); setStage(1, 1'b1, 5'd0); setStage(2, 1'b1, 5'd0);
        #1;
        check("lit_fwdA_r0", int'(bus.o_forwardA), 0);
        check("lit_fwdB_r0", int'(bus.o_forwardB), 0);

        // Store-data forwarding from MEM/WB only.
        nextCycle(); idle();
        bus.in_EX_MEM_memWrite = 1'b1;
        bus.in_EX_MEM_Rt_address = 5'd12;
        setStage(1, 1'b1, 5'd12);
        #1;
        check("lit_store_on", int'(bus.o_forward_store), 1);
        nextCycle();
        bus.in_EX_MEM_memWrite = 1'b0;
        #1;
        check("lit_store_nowrite", int'(bus.o_forward_store), 0);
        nextCycle();
        bus.in_EX_MEM_memWrite = 1'b1;
        setStage(1, 1'b1, 5'd11); setStage(0, 1'b1, 5'd12);
        #1;
        check("lit_store_stage0", int'(bus.o_forward_store), 0);

        // Load-use: stall exactly LOAD_LAT cycles.
        nextCycle(); idle();
        bus.in_ID_EX_memRead = 1'b1;
        bus.in_ID_EX_Rd_address = 5'd9;
        bus.in_ID_Rs_address = 5'd9;
        #1;
        check("lit_lu_stall0", int'(bus.o_stall), 1);
        check("lit_lu_bubble0", int'(bus.o_bubble_ID_EX), 1);
        for (int i = 1; i <= 3; i++) begin
            nextCycle();
            bus.in_ID_EX_memRead = 1'b0;
            bus.in_ID_EX_Rd_address = '0;
            #1;
            check($sformatf("lit_lu_stall%0d", i), int'(bus.o_stall), (i < 3) ? 1 : 0);
        end

        // Flush during LD_WAIT ends the stall at the next edge.
        nextCycle(); idle();
        bus.in_ID_EX_memRead = 1'b1;
        bus.in_ID_EX_Rd_address = 5'd9;
        bus.in_ID_Rs_address = 5'd2;
        bus.in_ID_Rt_address = 5'd9;
        bus.in_ID_uses_Rt = 1'b1;
        #1;
        check("lit_lurt_stall", int'(bus.o_stall), 1);
        nextCycle();
        bus.in_ID_EX_memRead = 1'b0;
        bus.in_ID_EX_Rd_address = '0;
        bus.in_flush = 1'b1;
        #1;
        check("lit_flush_wait", int'(bus.o_stall), 1);
        nextCycle(); idle();
        #1;
        check("lit_flush_done", int'(bus.o_stall), 0);

        // Mult/div: dependent ID stalls MD_LAT cycles.
        nextCycle(); idle();
        bus.in_ID_EX_md_start = 1'b1;
        bus.in_ID_EX_Rd_address = 5'd10;
        bus.in_ID_Rs_address = 5'd3;
        #1;
        check("lit_md_start_stall", int'(bus.o_stall), 0);
        check("lit_md_start_busy", int'(bus.o_md_busy), 0);
        for (int i = 1; i <= 5; i++) begin
            nextCycle(); idle();
            bus.in_ID_Rs_address = 5'd10;
            #1;
            check($sformatf("lit_md_stall%0d", i), int'(bus.o_stall), (i <= 4) ? 1 : 0);
            check($sformatf("lit_md_busy%0d", i), int'(bus.o_md_busy), (i <= 4) ? 1 : 0);
        end

        // Independent instruction is not stalled; a second md op is.
        nextCycle(); idle();
        bus.in_ID_EX_md_start = 1'b1;
        bus.in_ID_EX_Rd_address = 5'd11;
        nextCycle(); idle();
        bus.in_ID_Rs_address = 5'd4;
        bus.in_ID_Rt_address = 5'd5;
        bus.in_ID_uses_Rt = 1'b1;
        #1;
        check("lit_md_indep_stall", int'(bus.o_stall), 0);
        check("lit_md_indep_busy", int'(bus.o_md_busy), 1);
        nextCycle();
        bus.in_ID_md_op = 1'b1;
        #1;
        check("lit_md_op_stall", int'(bus.o_stall), 1);
        repeat (4) begin
            nextCycle(); idle();
        end

        // Reset in LD_WAIT with a mult/div in flight.
        nextCycle(); idle();
        bus.in_ID_EX_md_start = 1'b1;
        bus.in_ID_EX_Rd_address = 5'd12;
        nextCycle(); idle();
        nextCycle(); idle();
        bus.in_ID_EX_memRead = 1'b1;
        bus.in_ID_EX_Rd_address = 5'd9;
        bus.in_ID_Rs_address = 5'd9;
        nextCycle(); idle();
        bus.in_ID_Rs_address = 5'd9;
        #1;
        check("lit_pre_rst_stall", int'(bus.o_stall), 1);
        check("lit_pre_rst_busy", int'(bus.o_md_busy), 1);
        #1 reset = 1'b0;
        #1;
        check("lit_async_stall", int'(bus.o_stall), 0);
        check("lit_async_bubble", int'(bus.o_bubble_ID_EX), 0);
        check("lit_async_busy", int'(bus.o_md_busy), 0);
        @(negedge clk);
        nextCycle();
        #1 reset = 1'b1;
        nextCycle();
        #1;
        check("lit_post_rst_stall", int'(bus.o_stall), 0);
        check("lit_post_rst_busy", int'(bus.o_md_busy), 0);

        repeat (3) nextCycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
